store_lane_buffer: RTL and testbench

- Parametrised successor to the store data formatter for the multicycle datapath.
- Accepts store requests (address, size, raw register data) over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Emits lane-aligned write beats with byte enables to the data memory port over a second valid/ready handshake.
- Handles 32- or 64-bit buses; optionally splits misaligned stores into two beats.

---
 rtl/store_lane_buffer_if.sv | 41 ++++
 rtl/store_lane_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_store_lane_buffer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/store_lane_buffer_if.sv
// ---------------------------------------------------------------------------
// store_lane_buffer_if
//   Bundles the two handshakes of the store lane buffer:
//     - request side : req_valid/req_ready with req_addr, req_size, req_data
//     - memory side  : mem_valid/mem_ready with mem_addr, mem_wdata, mem_be
//     - status       : err (one-cycle drop pulse), err_cnt (saturating count)
//   Modports:
//     master : the environment (issues requests, acts as the data memory)
//     slave  : the store lane buffer itself
// ---------------------------------------------------------------------------
interface store_lane_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  logic              err;
  logic [7:0]        err_cnt;

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err, err_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err, err_cnt
  );
endinterface

// File: rtl/store_lane_buffer.sv
// ---------------------------------------------------------------------------
// store_lane_buffer
//   Queues store requests in a DEPTH-entry FIFO and emits lane-aligned write
//   beats (data shifted into byte lanes, unused lanes zeroed, byte enables)
//   to the data memory port. Illegal requests (dword on a 32-bit bus) are
//   dropped with an err pulse and a saturating err_cnt increment.
//
//   Optional feature macro: STORE_MISALIGN_SPLIT_EN
//     defined   : a store crossing an NB-byte boundary is split into two beats
//     undefined : such a store is dropped like an illegal one
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    store_lane_buffer_if.slave (request handshake, memory handshake,
//            err / err_cnt status)
// ---------------------------------------------------------------------------
module store_lane_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  store_lane_buffer_if.slave    bus
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT
`ifdef STORE_MISALIGN_SPLIT_EN
    ,
    S_SPLIT0
`endif
  } state_e;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // ---------------- request FIFO ----------------
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [1:0]        size_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW:0]       wr_ptr_q, rd_ptr_q;

  logic fifo_empty, fifo_full, push, pop;

  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign bus.req_ready = !fifo_full;
  assign push          = bus.req_valid && !fifo_full;

  // NOTE: storage arrays are not reset; the pointers alone say which entries
  // are valid, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[PW-1:0]] <= bus.req_addr;
      size_mem[wr_ptr_q[PW-1:0]] <= bus.req_size;
      data_mem[wr_ptr_q[PW-1:0]] <= bus.req_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // ---------------- head-of-FIFO formatting ----------------
  logic [ADDR_W-1:0] h_addr;
  logic [1:0]        h_size;
  logic [DATA_W-1:0] h_data;
  logic [OW-1:0]     o;
  logic [3:0]        n;
  logic [4:0]        span;
  logic [NB-1:0]     mask, be0;
  logic [DATA_W-1:0] data0;
  logic [ADDR_W-1:0] addr0;
  logic              misaligned, illegal, drop;

  assign h_addr     = addr_mem[rd_ptr_q[PW-1:0]];
  assign h_size     = size_mem[rd_ptr_q[PW-1:0]];
  assign h_data     = data_mem[rd_ptr_q[PW-1:0]];
  assign o          = h_addr[OW-1:0];
  assign n          = 4'd1 << h_size;
  assign mask       = ~({NB{1'b1}} << n);
  assign span       = 5'(o) + 5'(n);
  assign misaligned = (span > 5'(NB));
  assign illegal    = (DATA_W == 32) && (h_size == 2'd3);
  assign be0        = mask << o;
  assign data0      = (h_data << {o, 3'b000}) & lane_mask(be0);
  assign addr0      = {h_addr[ADDR_W-1:OW], {OW{1'b0}}};

`ifdef STORE_MISALIGN_SPLIT_EN
  // The upper part of a boundary-crossing store lands in the low lanes of
  // the next NB-aligned word.
  logic [OW:0]       sh1;
  logic [NB-1:0]     be1;
  logic [DATA_W-1:0] data1;
  logic [ADDR_W-1:0] addr1;

  assign sh1   = (OW+1)'(NB) - (OW+1)'(o);
  assign be1   = mask >> sh1;
  assign data1 = (h_data >> {sh1, 3'b000}) & lane_mask(be1);
  assign addr1 = addr0 + ADDR_W'(NB);
  assign drop  = illegal;
`else
  assign drop  = illegal || misaligned;
`endif

  // ---------------- output FSM ----------------
  state_e            state_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [NB-1:0]     mem_be_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic [ADDR_W-1:0] b1_addr_q;
  logic [DATA_W-1:0] b1_data_q;
  logic [NB-1:0]     b1_be_q;
`endif

  // A new request is taken only when the output register is free or is
  // being emptied by a handshake; SPLIT0 never pops, so beat1 cannot be
  // overtaken by a later request.
  assign pop = !fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_BEAT) && bus.mem_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
      b1_addr_q   <= '0;
      b1_data_q   <= '0;
      b1_be_q     <= '0;
`endif
    end else begin
      err_q <= 1'b0;

      case (state_q)
        S_BEAT: begin
          if (bus.mem_ready && fifo_empty) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
`ifdef STORE_MISALIGN_SPLIT_EN
        S_SPLIT0: begin
          if (bus.mem_ready) begin
            mem_addr_q  <= b1_addr_q;
            mem_wdata_q <= b1_data_q;
            mem_be_q    <= b1_be_q;
            state_q     <= S_BEAT;
          end
        end
`endif
        default: ;
      endcase

      // NOTE: this block comes after the case on purpose; when a pop happens
      // its non-blocking assignments are the last ones scheduled and win.
      if (pop) begin
        if (drop) begin
          mem_valid_q <= 1'b0;
          err_q       <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          state_q     <= S_IDLE;
        end else begin
          mem_valid_q <= 1'b1;
          mem_addr_q  <= addr0;
          mem_wdata_q <= data0;
          mem_be_q    <= be0;
`ifdef STORE_MISALIGN_SPLIT_EN
          b1_addr_q   <= addr1;
          b1_data_q   <= data1;
          b1_be_q     <= be1;
          state_q     <= misaligned ? S_SPLIT0 : S_BEAT;
`else
          state_q     <= S_BEAT;
`endif
        end
      end
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_store_lane_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_lane_buffer
//   Directed bench for store_lane_buffer (DATA_W = 32, DEPTH = 4). Inputs are
//   driven and outputs sampled on the falling clock edge. Expected values are
//   hand-computed constants. Adapts to STORE_MISALIGN_SPLIT_EN.
// ---------------------------------------------------------------------------
module tb_store_lane_buffer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  store_lane_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  store_lane_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 2'd0;
    bus.req_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Presents one request for one rising edge; returns on the next falling edge.
  task automatic send(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_data  = data;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
    check({tag, " valid"}, 64'(bus.mem_valid), 64'd1);
    check({tag, " addr"},  64'(bus.mem_addr),  64'(addr));
    check({tag, " wdata"}, 64'(bus.mem_wdata), 64'(data));
    check({tag, " be"},    64'(bus.mem_be),    64'(be));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    logic rdy;

    reset = 1'b1;
    idle_inputs();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("reset mem_valid", 64'(bus.mem_valid), 64'd0);
    check("reset mem_addr",  64'(bus.mem_addr),  64'd0);
    check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("reset mem_be",    64'(bus.mem_be),    64'd0);
    check("reset err",       64'(bus.err),       64'd0);
    check("reset err_cnt",   64'(bus.err_cnt),   64'd0);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Word store: one cycle latency, single beat.
    send(32'h1000, 2'd2, 32'hDEADBEEF);
    check("word latency idle", 64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    expect_beat("word", 32'h1000, 32'hDEADBEEF, 4'b1111);
    @(negedge clk);
    check("word single beat", 64'(bus.mem_valid), 64'd0);

    // Byte store into lane 3; upper garbage bits of req_data must not leak.
    send(32'h1003, 2'd0, 32'h123456AB);
    @(negedge clk);
    expect_beat("byte", 32'h1000, 32'hAB000000, 4'b1000);
    @(negedge clk);

    // Aligned half into lanes 2..3.
    send(32'h1002, 2'd1, 32'hCAFEBEEF);
    @(negedge clk);
    expect_beat("half", 32'h1000, 32'hBEEF0000, 4'b1100);
    @(negedge clk);

    // Misaligned half crossing the word boundary.
    send(32'h1003, 2'd1, 32'h00001234);
`ifdef STORE_MISALIGN_SPLIT_EN
    @(negedge clk);
    expect_beat("split beat0", 32'h1000, 32'h34000000, 4'b1000);
    @(negedge clk);
    expect_beat("split beat1", 32'h1004, 32'h00000012, 4'b0001);
    @(negedge clk);
    check("split done", 64'(bus.mem_valid), 64'd0);
    check("split no err", 64'(bus.err_cnt), 64'd0);
`else
    @(negedge clk);
    check("misalign err pulse", 64'(bus.err),       64'd1);
    check("misalign err_cnt",   64'(bus.err_cnt),   64'd1);
    check("misalign no beat",   64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    check("misalign err ends",  64'(bus.err),       64'd0);
    check("misalign still idle", 64'(bus.mem_valid), 64'd0);
`endif

    // Backpressure: DEPTH + 1 requests fit, then beats drain one per cycle.
    do_reset();
    bus.mem_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 32'h2000 + 32'(4 * accepted);
      bus.req_data  = 32'hA0000000 | 32'(accepted);
      rdy = bus.req_ready;
      @(negedge clk);
      if (rdy) accepted++;
    end
    idle_inputs();
    check("bp accepted", 64'(accepted), 64'd5);
    check("bp req_ready low", 64'(bus.req_ready), 64'd0);
    expect_beat("bp hold", 32'h2000, 32'hA0000000, 4'b1111);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_beat($sformatf("bp drain%0d", i), 32'h2000 + 32'(4 * i),
                  32'hA0000000 | 32'(i), 4'b1111);
      @(negedge clk);
    end
    check("bp drained", 64'(bus.mem_valid), 64'd0);
    check("bp req_ready back", 64'(bus.req_ready), 64'd1);

    // Reset while a beat is pending: output drops at once, nothing follows.
    do_reset();
    bus.mem_ready = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    send(32'h1003, 2'd1, 32'h00001234);
`else
    send(32'h1000, 2'd2, 32'h11111111);
`endif
    send(32'h1010, 2'd2, 32'h22222222);
    check("pre-reset valid", 64'(bus.mem_valid), 64'd1);
    #2 reset = 1'b1;
    #1 check("async reset drop", 64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset no beat", 64'(bus.mem_valid), 64'd0);
    check("post-reset req_ready", 64'(bus.req_ready), 64'd1);
    check("post-reset err_cnt", 64'(bus.err_cnt), 64'd0);

    // Illegal dword on a 32-bit bus, then saturation of err_cnt.
    do_reset();
    send(32'h3000, 2'd3, 32'hFFFFFFFF);
    @(negedge clk);
    check("dword err pulse", 64'(bus.err),       64'd1);
    check("dword err_cnt",   64'(bus.err_cnt),   64'd1);
    check("dword no beat",   64'(bus.mem_valid), 64'd0);
    @(negedge clk);
    check("dword err ends",  64'(bus.err),       64'd0);
    for (int i = 0; i < 254; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h3000;
      bus.req_size  = 2'd3;
      bus.req_data  = 32'h0;
      @(negedge clk);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    check("err_cnt at 255", 64'(bus.err_cnt), 64'd255);
    check("dword stream no beat", 64'(bus.mem_valid), 64'd0);
    send(32'h3000, 2'd3, 32'h0);
    @(negedge clk);
    check("err pulse at sat", 64'(bus.err), 64'd1);
    @(negedge clk);
    check("err_cnt saturated", 64'(bus.err_cnt), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
